// File: rtl/grpci2_axi_lite_mst.sv
// grpci2_axi_lite_mst: AXI-lite slave to AHB master bridge.
//
// Local logic issues single-beat AXI-lite reads and writes. The bridge turns
// each one into a single AHB NONSEQ transfer on the grpci2 ahb_slv port.
// Only one access is in flight at a time.
//
// Ports:
//   aclk, areset        - single clock; synchronous active-high reset
//   axi_s_aw*/w*/b*     - AXI-lite write address, data and response channels
//   axi_s_ar*/r*        - AXI-lite read address and data channels
//   ahb_m_hbusreq/hgrant - AHB bus request and grant
//   ahb_m_hready/hresp/hrdata - AHB transfer completion, status and read data
//   ahb_m_htrans/haddr/hwrite/hsize/hwdata - AHB transfer control and write data
//
// A wrapper ties hprot=HPROT_VAL, hlock=0 and hburst=SINGLE.
//
// Optional feature: define AHB_TIMEOUT_EN to add a data-phase watchdog.
// The watchdog ends the access with SLVERR after TIMEOUT_CYCLES cycles of
// hready low.
module grpci2_axi_lite_mst #(
   parameter int unsigned TIMEOUT_CYCLES = 1024,
   parameter logic [3:0]  HPROT_VAL      = 4'b0011
) (
   input  logic        aclk,
   input  logic        areset,
   input  logic        axi_s_awvalid,
   output logic        axi_s_awready,
   input  logic [31:0] axi_s_awaddr,
   input  logic        axi_s_wvalid,
   output logic        axi_s_wready,
   input  logic [31:0] axi_s_wdata,
   input  logic [3:0]  axi_s_wstrb,
   output logic        axi_s_bvalid,
   input  logic        axi_s_bready,
   output logic [1:0]  axi_s_bresp,
   input  logic        axi_s_arvalid,
   output logic        axi_s_arready,
   input  logic [31:0] axi_s_araddr,
   output logic        axi_s_rvalid,
   input  logic        axi_s_rready,
   output logic [31:0] axi_s_rdata,
   output logic [1:0]  axi_s_rresp,
   output logic        ahb_m_hbusreq,
   input  logic        ahb_m_hgrant,
   input  logic        ahb_m_hready,
   input  logic [1:0]  ahb_m_hresp,
   input  logic [31:0] ahb_m_hrdata,
   output logic [1:0]  ahb_m_htrans,
   output logic [31:0] ahb_m_haddr,
   output logic        ahb_m_hwrite,
   output logic [2:0]  ahb_m_hsize,
   output logic [31:0] ahb_m_hwdata
);

   localparam logic [1:0] HtransIdle   = 2'b00;
   localparam logic [1:0] HtransNonseq = 2'b10;
   localparam logic [1:0] HrespOkay    = 2'b00;
   localparam logic [1:0] HrespError   = 2'b01;
   localparam logic [1:0] AxiOkay      = 2'b00;
   localparam logic [1:0] AxiSlverr    = 2'b10;

   typedef enum logic [2:0] {StIdle, StReq, StAddr, StData, StResp} state_e;

   state_e      state_q;
   logic        last_wr_q;
   logic        hbusreq_q;
   logic [1:0]  htrans_q;
   logic [31:0] haddr_q;
   logic        hwrite_q;
   logic [2:0]  hsize_q;
   logic [31:0] hwdata_q;
   logic        bvalid_q;
   logic        rvalid_q;
   logic [1:0]  resp_q;
   logic [31:0] rdata_q;

   logic       pick_wr, pick_rd;
   logic       strb_ok;
   logic [2:0] strb_size;
   logic [1:0] strb_lo;

   // Both channels pending: alternate, starting with the write after reset.
   assign pick_wr = axi_s_awvalid && axi_s_wvalid && (!axi_s_arvalid || !last_wr_q);
   assign pick_rd = axi_s_arvalid && (!(axi_s_awvalid && axi_s_wvalid) || last_wr_q);

   assign axi_s_awready = (state_q == StIdle) && pick_wr;
   assign axi_s_wready  = (state_q == StIdle) && pick_wr;
   assign axi_s_arready = (state_q == StIdle) && pick_rd;

   // Only naturally aligned word, halfword and byte strobes map onto an AHB size.
   always_comb begin
      strb_ok   = 1'b1;
      strb_size = 3'b010;
      strb_lo   = 2'b00;
      case (axi_s_wstrb)
         4'b1111: ;
         4'b0011: strb_size = 3'b001;
         4'b1100: begin strb_size = 3'b001; strb_lo = 2'b10; end
         4'b0001: strb_size = 3'b000;
         4'b0010: begin strb_size = 3'b000; strb_lo = 2'b01; end
         4'b0100: begin strb_size = 3'b000; strb_lo = 2'b10; end
         4'b1000: begin strb_size = 3'b000; strb_lo = 2'b11; end
         default: strb_ok = 1'b0;
      endcase
   end

`ifdef AHB_TIMEOUT_EN
   logic [31:0] tmo_q;
`else
   logic [31:0] unused_timeout;
   assign unused_timeout = TIMEOUT_CYCLES;
`endif
   logic [7:0] unused_misc;
   assign unused_misc = {HPROT_VAL, axi_s_awaddr[1:0], axi_s_araddr[1:0]};

   always_ff @(posedge aclk) begin
      if (areset) begin
         state_q   <= StIdle;
         last_wr_q <= 1'b0;
         hbusreq_q <= 1'b0;
         htrans_q  <= HtransIdle;
         haddr_q   <= '0;
         hwrite_q  <= 1'b0;
         hsize_q   <= '0;
         hwdata_q  <= '0;
         bvalid_q  <= 1'b0;
         rvalid_q  <= 1'b0;
         resp_q    <= AxiOkay;
         rdata_q   <= '0;
`ifdef AHB_TIMEOUT_EN
         tmo_q     <= '0;
`endif
      end else begin
         case (state_q)
            StIdle: begin
               if (pick_wr) begin
                  haddr_q  <= {axi_s_awaddr[31:2], strb_lo};
                  hwrite_q <= 1'b1;
                  hsize_q  <= strb_size;
                  hwdata_q <= axi_s_wdata;
                  if (strb_ok) begin
                     hbusreq_q <= 1'b1;
                     state_q   <= StReq;
                  end else begin
                     // Unsupported strobe: answer directly, never touch the bus.
                     bvalid_q <= 1'b1;
                     resp_q   <= AxiSlverr;
                     state_q  <= StResp;
                  end
               end else if (pick_rd) begin
                  haddr_q   <= {axi_s_araddr[31:2], 2'b00};
                  hwrite_q  <= 1'b0;
                  hsize_q   <= 3'b010;
                  hbusreq_q <= 1'b1;
                  state_q   <= StReq;
               end
            end
            StReq: begin
               if (ahb_m_hgrant && ahb_m_hready) begin
                  htrans_q <= HtransNonseq;
                  state_q  <= StAddr;
               end
            end
            StAddr: begin
               if (ahb_m_hready) begin
                  htrans_q  <= HtransIdle;
                  hbusreq_q <= 1'b0;
                  state_q   <= StData;
`ifdef AHB_TIMEOUT_EN
                  tmo_q     <= '0;
`endif
               end
            end
            StData: begin
               if (ahb_m_hready) begin
                  case (ahb_m_hresp)
                     HrespOkay: begin
                        if (!hwrite_q) rdata_q <= ahb_m_hrdata;
                        resp_q   <= AxiOkay;
                        bvalid_q <= hwrite_q;
                        rvalid_q <= !hwrite_q;
                        state_q  <= StResp;
                     end
                     HrespError: begin
                        resp_q   <= AxiSlverr;
                        bvalid_q <= hwrite_q;
                        rvalid_q <= !hwrite_q;
                        state_q  <= StResp;
                     end
                     // RETRY / SPLIT: rearbitrate and replay the same transfer.
                     default: begin
                        hbusreq_q <= 1'b1;
                        state_q   <= StReq;
                     end
                  endcase
               end
`ifdef AHB_TIMEOUT_EN
               else if (tmo_q == TIMEOUT_CYCLES - 1) begin
                  rdata_q  <= 32'hFFFF_FFFF;
                  resp_q   <= AxiSlverr;
                  bvalid_q <= hwrite_q;
                  rvalid_q <= !hwrite_q;
                  state_q  <= StResp;
               end else begin
                  tmo_q <= tmo_q + 32'd1;
               end
`endif
            end
            StResp: begin
               if ((hwrite_q && axi_s_bready) || (!hwrite_q && axi_s_rready)) begin
                  bvalid_q  <= 1'b0;
                  rvalid_q  <= 1'b0;
                  last_wr_q <= hwrite_q;
                  state_q   <= StIdle;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign axi_s_bvalid  = bvalid_q;
   assign axi_s_bresp   = resp_q;
   assign axi_s_rvalid  = rvalid_q;
   assign axi_s_rresp   = resp_q;
   assign axi_s_rdata   = rdata_q;
   assign ahb_m_hbusreq = hbusreq_q;
   assign ahb_m_htrans  = htrans_q;
   assign ahb_m_haddr   = haddr_q;
   assign ahb_m_hwrite  = hwrite_q;
   assign ahb_m_hsize   = hsize_q;
   assign ahb_m_hwdata  = hwdata_q;

endmodule
